// File: rtl/prog_frame_loader.sv
// prog_frame_loader
//   Parses a UART byte stream carrying a program image and writes it into the
//   instruction RAM, holding the core in reset until a complete frame with a
//   good checksum has been loaded.
//
//   Frame: 0xA5, LEN_LO, LEN_HI, N words (4 bytes each, LSB first), CSUM.
//   CSUM is the XOR of the two length bytes and every data byte.
//
// Ports
//   clk_i       system clock
//   rst_i       asynchronous active-high reset
//   rx_dv_i     one-cycle strobe, rx_byte_i valid
//   rx_byte_i   received byte
//   we_o        one-cycle instruction-RAM write strobe
//   addr_o      word address of the current write
//   wdata_o     write data word
//   core_rst_o  holds the core in reset until a frame loads successfully
//   busy_o      high while a frame is being parsed
//   err_o       sticky error flag (bad length, bad checksum, timeout)
//   done_o      sticky load-complete flag
module prog_frame_loader #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_dv_i,
    input  logic [7:0]        rx_byte_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic              core_rst_o,
    output logic              busy_o,
    output logic              err_o,
    output logic              done_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [7:0] SYNC = 8'hA5;

    // Largest word count that still fits the RAM: N may equal 2^ADDR_W.
    localparam int unsigned MAX_N = (ADDR_W >= 16) ? 32'd65536 : (32'd1 << ADDR_W);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       words_q, words_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              core_rst_q, core_rst_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic              busy;
    logic              timeout;
    logic [15:0]       n_words;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        words_d    = words_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        err_d      = err_q;
        done_d     = done_q;
        core_rst_d = core_rst_q;

        busy    = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                  (state_q == S_DATA)   || (state_q == S_CSUM);
        timeout = busy && (tmo_q == TMO_LIMIT);
        n_words = {rx_byte_i, len_q[7:0]};

        // Idle-gap counter only runs inside a frame; any byte restarts it.
        if (!busy || rx_dv_i || timeout) tmo_d = '0;
        else                             tmo_d = tmo_q + 1'b1;

        // Timeout wins over a byte arriving in the same cycle (byte dropped).
        if (timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else if (rx_dv_i) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_byte_i == SYNC) begin
                        state_d    = S_LEN_LO;
                        csum_d     = '0;
                        words_d    = '0;
                        byte_cnt_d = '0;
                    end
                end
                S_LEN_LO: begin
                    len_d[7:0] = rx_byte_i;
                    csum_d     = csum_q ^ rx_byte_i;
                    state_d    = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_d[15:8] = rx_byte_i;
                    csum_d      = csum_q ^ rx_byte_i;
                    if ({16'd0, n_words} > MAX_N) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (n_words == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    csum_d     = csum_q ^ rx_byte_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0:    wdata_d[7:0]   = rx_byte_i;
                        2'd1:    wdata_d[15:8]  = rx_byte_i;
                        2'd2:    wdata_d[23:16] = rx_byte_i;
                        default: wdata_d[31:24] = rx_byte_i;
                    endcase
                    // Word complete: the strobe lands next cycle with the
                    // address and data registered alongside it.
                    if (byte_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = ADDR_W'(words_q);
                        words_d = words_q + 16'd1;
                        if (words_q + 16'd1 == len_q) state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (rx_byte_i == csum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_DONE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            words_q    <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            core_rst_q <= 1'b1;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            words_q    <= words_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            err_q      <= err_d;
            done_q     <= done_d;
            core_rst_q <= core_rst_d;
            tmo_q      <= tmo_d;
        end
    end

    assign we_o       = we_q;
    assign addr_o     = addr_q;
    assign wdata_o    = wdata_q;
    assign core_rst_o = core_rst_q;
    assign busy_o     = busy;
    assign err_o      = err_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_prog_frame_loader.sv
// Bench for prog_frame_loader (ADDR_W=2, TIMEOUT=100).
// Frame records are applied in a loop; expected RAM writes are queued as the
// completing data byte is driven and checked whenever we_o is seen.
module tb_prog_frame_loader;

    localparam int ADDR_W  = 2;
    localparam int TIMEOUT = 100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_dv = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              we_o;
    logic [ADDR_W-1:0] addr_o;
    logic [31:0]       wdata_o;
    logic              core_rst_o, busy_o, err_o, done_o;

    prog_frame_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte),
        .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .core_rst_o(core_rst_o), .busy_o(busy_o), .err_o(err_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    typedef struct {
        logic       rst_before;
        int         gap;
        int         n;
        logic [7:0] b[32];
        int         so;     // index of the sync byte
        int         nw;     // writes expected
        logic       e_err, e_done, e_core;
    } vec_t;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    vec_t vecs[8];
    wr_t  exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle; observe the write port at the negedge.
    task automatic tick();
        wr_t w;
        @(negedge clk);
        if (we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_we: addr %0d data %h, no write expected", addr_o, wdata_o);
            end else begin
                w = exp_q.pop_front();
                chk("we_addr", 32'(addr_o), 32'(w.a));
                chk("we_data", wdata_o, w.d);
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input bq_t q, input int so, input int nw, input int gap);
        int rel;
        wr_t w;
        for (int j = 0; j < q.size(); j++) begin
            rel = j - so - 3;
            if (rel >= 0 && rel % 4 == 3 && rel / 4 < nw) begin
                w.a = ADDR_W'(rel / 4);
                w.d = {q[j], q[j-1], q[j-2], q[j-3]};
                exp_q.push_back(w);
            end
            send(q[j], gap);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        rx_dv = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
    endtask

    task automatic check_end(input string tag, input logic e_err, input logic e_done, input logic e_core);
        repeat (4) tick();
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'(e_err));
        chk({tag, "_done"}, 32'(done_o), 32'(e_done));
        chk({tag, "_core_rst"}, 32'(core_rst_o), 32'(e_core));
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        exp_q.delete();
    endtask

    function automatic bq_t build(input bq_t pre, input logic [15:0] n, input wq_t words,
                                  input logic [7:0] bad);
        bq_t q = pre;
        logic [7:0] cs;
        q.push_back(8'hA5);
        q.push_back(n[7:0]);
        q.push_back(n[15:8]);
        cs = n[7:0] ^ n[15:8];
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) begin
                q.push_back(words[i][8*k +: 8]);
                cs = cs ^ words[i][8*k +: 8];
            end
        end
        q.push_back(cs ^ bad);
        return q;
    endfunction

    function automatic void load(input int i, input logic r, input int gap, input bq_t q,
                                 input int so, input int nw,
                                 input logic ee, input logic ed, input logic ec);
        vecs[i].rst_before = r;
        vecs[i].gap = gap;
        vecs[i].n   = q.size();
        foreach (q[j]) vecs[i].b[j] = q[j];
        vecs[i].so  = so;
        vecs[i].nw  = nw;
        vecs[i].e_err  = ee;
        vecs[i].e_done = ed;
        vecs[i].e_core = ec;
    endfunction

    initial begin
        bq_t q;
        wq_t w4;
        w4 = '{32'h0403_0201, 32'h1122_3344, 32'hA5A5_0000, 32'hFFFF_FFFF};

        // Two words back-to-back, checksum written out by hand (0x28).
        load(0, 1'b1, 0, '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28}, 0, 2, 1'b0, 1'b1, 1'b0);
        // Leading junk, then an empty frame.
        load(1, 1'b1, 3, '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00}, 2, 0, 1'b0, 1'b1, 1'b0);
        // Bad checksum: word still written, then error.
        load(2, 1'b1, 1, build('{}, 16'd1, '{32'h4433_2211}, 8'h01), 0, 1, 1'b1, 1'b0, 1'b1);
        // Retry after bad checksum: loads from addr 0, err stays.
        load(3, 1'b0, 0, build('{8'h5A}, 16'd1, '{32'hCAFE_BABE}, 8'h00), 1, 1, 1'b1, 1'b1, 1'b0);
        // Length 5 exceeds 2^ADDR_W: error on LEN_HI.
        load(4, 1'b1, 0, '{8'hA5, 8'h05, 8'h00}, 0, 0, 1'b1, 1'b0, 1'b1);
        // Retry with the maximum length 4.
        load(5, 1'b0, 2, build('{}, 16'd4, w4, 8'h00), 0, 4, 1'b1, 1'b1, 1'b0);
        // Maximum length from clean reset.
        load(6, 1'b1, 0, build('{}, 16'd4, w4, 8'h00), 0, 4, 1'b0, 1'b1, 1'b0);
        // After DONE, a further frame is ignored.
        q = build('{}, 16'd0, '{}, 8'h00);
        q = build(q, 16'd1, '{32'hDDCC_BBAA}, 8'h00);
        load(7, 1'b1, 0, q, 0, 0, 1'b0, 1'b1, 1'b0);

        // Reset values.
        @(negedge clk);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_addr", 32'(addr_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_core_rst", 32'(core_rst_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rst_before) do_reset();
            q.delete();
            for (int j = 0; j < vecs[i].n; j++) q.push_back(vecs[i].b[j]);
            send_frame(q, vecs[i].so, vecs[i].nw, vecs[i].gap);
            check_end($sformatf("vec%0d", i), vecs[i].e_err, vecs[i].e_done, vecs[i].e_core);
        end

        // Timeout inside a frame, then retry.
        do_reset();
        send_frame('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22}, 0, 0, 0);
        chk("tmo_busy_mid", 32'(busy_o), 32'd1);
        repeat (TIMEOUT - 5) tick();
        chk("tmo_err_early", 32'(err_o), 32'd0);
        chk("tmo_busy_early", 32'(busy_o), 32'd1);
        repeat (10) tick();
        chk("tmo_err", 32'(err_o), 32'd1);
        chk("tmo_busy", 32'(busy_o), 32'd0);
        chk("tmo_core_rst", 32'(core_rst_o), 32'd1);
        send(8'h33, 0);
        send(8'h44, 1);
        send_frame(build('{}, 16'd1, '{32'h0BAD_F00D}, 8'h00), 0, 1, 0);
        check_end("tmo_retry", 1'b1, 1'b1, 1'b0);

        // Reset in the middle of a frame.
        do_reset();
        send_frame(build('{}, 16'd2, '{32'h1, 32'h2}, 8'hFF), 0, 2, 0);
        send_frame('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22}, 0, 0, 0);
        chk("mid_busy", 32'(busy_o), 32'd1);
        chk("mid_err", 32'(err_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(we_o), 32'd0);
        chk("mid_rst_addr", 32'(addr_o), 32'd0);
        chk("mid_rst_wdata", wdata_o, 32'd0);
        chk("mid_rst_core_rst", 32'(core_rst_o), 32'd1);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_err", 32'(err_o), 32'd0);
        chk("mid_rst_done", 32'(done_o), 32'd0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
        send_frame(build('{}, 16'd1, '{32'h8765_4321}, 8'h00), 0, 1, 1);
        check_end("mid_reload", 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_frame_loader.md
PROG_FRAME_LOADER -- requirements
Module: prog_frame_loader

Interface
REQ-001 Parameter ADDR_W, default 14: instruction-RAM word-address width.
REQ-002 Parameter TIMEOUT, default 65535: max idle clk_i cycles between bytes inside a frame.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk_i  input  1  system clock.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 rx_dv_i  input  1  one-cycle strobe, UART byte valid.
REQ-007 rx_byte_i  input  8  received byte, valid when rx_dv_i=1.
REQ-008 we_o  output  1  one-cycle instruction-RAM write strobe.
REQ-009 addr_o  output  ADDR_W  word address of the current write.
REQ-010 wdata_o  output  32  write data word.
REQ-011 core_rst_o  output  1  active-high hold of the core; 1 until a frame loads successfully.
REQ-012 busy_o  output  1  high while a frame is being parsed.
REQ-013 err_o  output  1  sticky error flag.
REQ-014 done_o  output  1  sticky load-complete flag.

Function
REQ-015 Frame format: sync 0xA5, LEN_LO, LEN_HI (16-bit word count N), then N words of 4 bytes each, least-significant byte first, then CSUM.
REQ-016 States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE. Every transition advances only on a cycle with rx_dv_i=1, except timeout and reset.
REQ-017 IDLE: byte 0xA5 -> LEN_LO; any other byte is discarded and state holds.
REQ-018 LEN_LO -> LEN_HI -> DATA when N>0, or -> CSUM when N=0.
REQ-019 N > 2^ADDR_W: on the LEN_HI byte, set err_o and return to IDLE.
REQ-020 Running checksum: XOR of LEN_LO, LEN_HI and all data bytes; cleared on sync acceptance.
REQ-021 DATA: a 2-bit byte counter fills wdata_o[8k+7:8k]. On the 4th byte, we_o=1 for exactly the next cycle (1-cycle latency from that rx_dv_i), with addr_o = word index (0..N-1) and the completed word on wdata_o.
REQ-022 addr_o and wdata_o are held stable for the we_o cycle.
REQ-023 After word N-1 the state goes to CSUM.
REQ-024 CSUM: byte equal to running checksum -> DONE; mismatch -> set err_o and return to IDLE. Words already written are not rolled back.
REQ-025 DONE: done_o=1, core_rst_o=0 from the cycle after the CSUM byte. All further bytes are ignored until rst_i.
REQ-026 A failed frame (error or timeout) leaves core_rst_o=1. A subsequent frame is accepted (retry) with addr restarting at 0. err_o stays 1 until rst_i.
REQ-027 busy_o=1 in states LEN_LO, LEN_HI, DATA and CSUM.
REQ-028 Timeout: a cycle counter is cleared on each rx_dv_i. If it reaches TIMEOUT while busy_o=1, set err_o and go to IDLE. The counter is inactive in IDLE and DONE.
REQ-029 A byte arriving on the timeout cycle: the timeout takes priority and the byte is dropped.
REQ-030 rx_dv_i on consecutive cycles is legal and every byte is consumed.

Reset
REQ-031 rst_i=1 asynchronously sets: state IDLE, we_o=0, addr_o=0, wdata_o=0, core_rst_o=1, busy_o=0, err_o=0, done_o=0, checksum=0, counters=0.
REQ-032 Reset mid-frame abandons the frame with no write pulse. Release of rst_i is synchronous to clk_i and waits for a new sync.

Verification
REQ-033 Send A5 02 00 | 78 56 34 12 | EF BE AD DE | CSUM=0x02^0x00^0x78^0x56^0x34^0x12^0xEF^0xBE^0xAD^0xDE -> we_o pulses at addr 0 with 0x12345678 and at addr 1 with 0xDEADBEEF; then done_o=1, core_rst_o=0, err_o=0.
REQ-034 Send 00 FF A5 00 00 00 -> leading bytes ignored; no we_o; done_o=1, core_rst_o=0.
REQ-035 Send a frame with a wrong CSUM byte -> err_o=1, core_rst_o=1, back in IDLE. Then send a correct frame -> done_o=1, core_rst_o=0, err_o remains 1.
REQ-036 Send A5 01 00 11 22, then idle for TIMEOUT cycles (TIMEOUT=100 in this test) -> err_o=1, busy_o=0, no we_o.
REQ-037 Assert rst_i after the 2nd data byte of a frame -> all outputs at reset values immediately; no we_o; a following valid frame loads from addr 0.
REQ-038 With ADDR_W=2, send A5 05 00 -> err_o=1 on the LEN_HI byte; with A5 04 00 and 16 data bytes plus correct CSUM -> 4 writes at addr 0..3, done_o=1.
